ov7670_sccb_responder: RTL

OV7670_SCCB_RESPONDER -- requirements
Module: ov7670_sccb_responder

---
 rtl/ov7670_sccb_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/ov7670_sccb_responder.sv
// SCCB slave emulating the OV7670 register interface: 256x8 register file,
// auto-incrementing pointer, optional ACK drive (OV7670_SCCB_ACK_EN).
module ov7670_sccb_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  input  logic       siod_i,
  output logic       siod_oe,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       soft_rst
);

`ifdef OV7670_SCCB_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam int unsigned REGS = 256;

  typedef enum logic [3:0] {
    IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE
  } state_t;

  logic [2:0] sioc_sync_q, siod_sync_q;
  logic [7:0] regfile_q [REGS];

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       strobe_q, strobe_d;
  logic       soft_q, soft_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  logic       sioc_s, sioc_p, siod_s, siod_p;
  logic       rise_c, fall_c, start_c, stop_c;
  logic [7:0] byte_c, rd_byte_c;
  logic       we_c, id_match_c;

  // Two sync flops plus a history flop per line for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sioc_sync_q <= 3'b111;
      siod_sync_q <= 3'b111;
    end else begin
      sioc_sync_q <= {sioc_sync_q[1:0], sioc};
      siod_sync_q <= {siod_sync_q[1:0], siod_i};
    end
  end

  assign sioc_s  = sioc_sync_q[1];
  assign sioc_p  = sioc_sync_q[2];
  assign siod_s  = siod_sync_q[1];
  assign siod_p  = siod_sync_q[2];
  assign rise_c  = sioc_s & ~sioc_p;
  assign fall_c  = ~sioc_s & sioc_p;
  assign start_c = sioc_s & sioc_p & siod_p & ~siod_s;
  assign stop_c  = sioc_s & sioc_p & ~siod_p & siod_s;

  assign byte_c     = {sh_q[6:0], siod_s};
  assign rd_byte_c  = regfile_q[ptr_q];
  assign id_match_c = (sh_q[7:1] == DEV_ADDR);

  // Bus decode: bits sampled on SIOC rise, SIOD drive changes after SIOC fall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    strobe_d = 1'b0;
    soft_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    we_c     = 1'b0;
    if (stop_c) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
    end else if (start_c) begin
      state_d = ID;
      oe_d    = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ID, SUB, WDATA: begin
          if (fall_c) oe_d = 1'b0;
          if (rise_c) begin
            sh_d  = byte_c;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ID) begin
                state_d = ID_ACK;
              end else if (state_q == SUB) begin
                ptr_d   = byte_c;
                state_d = SUB_ACK;
              end else begin
                we_c     = 1'b1;
                strobe_d = 1'b1;
                addr_d   = ptr_q;
                data_d   = byte_c;
                soft_d   = (ptr_q == 8'h12) && byte_c[7];
                ptr_d    = ptr_q + 8'd1;
                state_d  = WDATA_ACK;
              end
            end
          end
        end
        ID_ACK: begin
          if (fall_c) oe_d = ACK_EN && id_match_c;
          if (rise_c) begin
            cnt_d   = 3'd0;
            state_d = !id_match_c ? IGNORE : (sh_q[0] ? RDATA : SUB);
          end
        end
        SUB_ACK, WDATA_ACK: begin
          if (fall_c) oe_d = ACK_EN;
          if (rise_c) begin
            cnt_d   = 3'd0;
            state_d = WDATA;
          end
        end
        RDATA: begin
          if (fall_c) oe_d = ~rd_byte_c[~cnt_q];
          if (rise_c) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = ptr_q + 8'd1;
              state_d = RD_ACK;
            end
          end
        end
        RD_ACK: begin
          if (fall_c) oe_d = 1'b0;
          if (rise_c) begin
            cnt_d   = 3'd0;
            state_d = siod_s ? IGNORE : RDATA;
          end
        end
        IGNORE: oe_d = 1'b0;
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      sh_q     <= 8'h00;
      ptr_q    <= 8'h00;
      oe_q     <= 1'b0;
      strobe_q <= 1'b0;
      soft_q   <= 1'b0;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      strobe_q <= strobe_d;
      soft_q   <= soft_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) regfile_q[i] <= 8'h00;
    end else if (we_c) begin
      regfile_q[ptr_q] <= byte_c;
    end
  end

  assign siod_oe   = oe_q;
  assign wr_strobe = strobe_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign soft_rst  = soft_q;

endmodule
